// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage buffer with a one-entry skid register, flush and halt tracking.
// in_ready is derived only from registered state, never from out_ready.
module pipe_stage_buf #(
  parameter int unsigned          WIDTH     = 32,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_halt,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_halt,
  output logic             halted,
  output logic [1:0]       occupancy
);

  // Encoding is {main_valid, skid_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    TWO   = 2'b11
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] main_data, main_data_n;
  logic [WIDTH-1:0] skid_data, skid_data_n;
  logic             main_halt, main_halt_n;
  logic             skid_halt, skid_halt_n;
  logic             halt_lock, halt_lock_n;
  logic             halted_q, halted_n;
  logic             acc, fire;

  assign in_ready  = !state[0] && !halt_lock;
  assign out_valid = state[1];
  assign out_data  = main_data;
  assign out_halt  = main_halt;
  assign halted    = halted_q;
  assign occupancy = {1'b0, state[1]} + {1'b0, state[0]};

  assign acc  = in_valid && in_ready;
  assign fire = out_valid && out_ready;

  always_comb begin
    state_n     = state;
    main_data_n = main_data;
    main_halt_n = main_halt;
    skid_data_n = skid_data;
    skid_halt_n = skid_halt;
    halt_lock_n = halt_lock;
    halted_n    = halted_q;
    if (flush) begin
      state_n     = EMPTY;
      main_data_n = RESET_VAL;
      main_halt_n = 1'b0;
      skid_data_n = RESET_VAL;
      skid_halt_n = 1'b0;
      // Once a halt has retired the core stays stopped, even across a squash.
      halt_lock_n = halted_q;
    end else begin
      if (acc && in_halt)    halt_lock_n = 1'b1;
      if (fire && main_halt) halted_n    = 1'b1;
      case (state)
        EMPTY: begin
          if (acc) begin
            state_n     = ONE;
            main_data_n = in_data;
            main_halt_n = in_halt;
          end
        end
        ONE: begin
          if (acc && fire) begin
            main_data_n = in_data;
            main_halt_n = in_halt;
          end else if (acc) begin
            state_n     = TWO;
            skid_data_n = in_data;
            skid_halt_n = in_halt;
          end else if (fire) begin
            state_n = EMPTY;
          end
        end
        TWO: begin
          if (fire) begin
            state_n     = ONE;
            main_data_n = skid_data;
            main_halt_n = skid_halt;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= EMPTY;
      main_data <= RESET_VAL;
      main_halt <= 1'b0;
      skid_data <= RESET_VAL;
      skid_halt <= 1'b0;
      halt_lock <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state     <= state_n;
      main_data <= main_data_n;
      main_halt <= main_halt_n;
      skid_data <= skid_data_n;
      skid_halt <= skid_halt_n;
      halt_lock <= halt_lock_n;
      halted_q  <= halted_n;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf: streaming, backpressure,
// flush, halt and reset scenarios with hand-computed expectations.
module tb_pipe_stage_buf;
  localparam int unsigned      W  = 16;
  localparam logic [W-1:0]     RV = 16'hA5A5;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         in_valid, in_ready, in_halt, flush;
  logic [W-1:0] in_data;
  logic         out_valid, out_ready, out_halt, halted;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  int checks   = 0;
  int failures = 0;

  pipe_stage_buf #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .CLK(CLK), .nRST(nRST),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_halt(in_halt),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_halt(out_halt),
    .halted(halted), .occupancy(occupancy)
  );

  always #5 CLK = ~CLK;

  // Advance one rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic h, input logic r);
    in_valid  = v;
    in_data   = d;
    in_halt   = h;
    out_ready = r;
  endtask

  task automatic do_reset();
    nRST = 1'b0; flush = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; flush = 1'b0;
    drive(1'b1, 16'h1234, 1'b1, 1'b1);
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== RV) begin failures++; $display("FAIL reset_out_data got=%h exp=%h", out_data, RV); end
    checks++; if (out_halt !== 1'b0) begin failures++; $display("FAIL reset_out_halt got=%b exp=0", out_halt); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    nRST = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_streaming();
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, W'(k), 1'b0, 1'b1);
      tick();
      checks++; if (out_data !== W'(k) || out_valid !== 1'b1) begin failures++; $display("FAIL stream_data%0d got=%h v=%b exp=%h v=1", k, out_data, out_valid, W'(k)); end
      checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin failures++; $display("FAIL stream_occ%0d got occ=%0d rdy=%b exp occ=1 rdy=1", k, occupancy, in_ready); end
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got occ=%0d v=%b exp occ=0 v=0", occupancy, out_valid); end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 16'h000A, 1'b0, 1'b1);
    tick();
    drive(1'b1, 16'h000B, 1'b0, 1'b0);
    tick();
    checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_full got occ=%0d rdy=%b exp occ=2 rdy=0", occupancy, in_ready); end
    checks++; if (out_data !== 16'h000A) begin failures++; $display("FAIL bp_hold_a got=%h exp=000a", out_data); end
    drive(1'b1, 16'h000C, 1'b0, 1'b0);
    tick();
    checks++; if (occupancy !== 2'd2 || out_data !== 16'h000A) begin failures++; $display("FAIL bp_c_refused got occ=%0d data=%h exp occ=2 data=000a", occupancy, out_data); end
    drive(1'b1, 16'h000C, 1'b0, 1'b1);
    tick();
    checks++; if (out_data !== 16'h000B || occupancy !== 2'd1 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_out_b got data=%h occ=%0d rdy=%b exp data=000b occ=1 rdy=1", out_data, occupancy, in_ready); end
    tick();
    checks++; if (out_data !== 16'h000C || occupancy !== 2'd1) begin failures++; $display("FAIL bp_out_c got data=%h occ=%0d exp data=000c occ=1", out_data, occupancy); end
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got occ=%0d v=%b exp occ=0 v=0", occupancy, out_valid); end
  endtask

  task automatic test_flush_two();
    drive(1'b1, 16'h000D, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h000E, 1'b0, 1'b0);
    tick();
    checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL flush_setup_occ got=%0d exp=2", occupancy); end
    flush = 1'b1;
    drive(1'b1, 16'h000F, 1'b0, 1'b1);
    tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin failures++; $display("FAIL flush_empty got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy); end
    checks++; if (out_data !== RV || in_ready !== 1'b1) begin failures++; $display("FAIL flush_data got data=%h rdy=%b exp data=%h rdy=1", out_data, in_ready, RV); end
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_capture got v=%b exp=0", out_valid); end
  endtask

  task automatic test_flush_before_halt();
    drive(1'b1, 16'h0009, 1'b1, 1'b0);
    tick();
    checks++; if (in_ready !== 1'b0 || out_halt !== 1'b1) begin failures++; $display("FAIL fbh_lock got rdy=%b halt=%b exp rdy=0 halt=1", in_ready, out_halt); end
    flush = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    flush = 1'b0;
    checks++; if (in_ready !== 1'b1 || halted !== 1'b0) begin failures++; $display("FAIL fbh_unlock got rdy=%b halted=%b exp rdy=1 halted=0", in_ready, halted); end
    checks++; if (out_valid !== 1'b0 || out_halt !== 1'b0) begin failures++; $display("FAIL fbh_clear got v=%b halt=%b exp v=0 halt=0", out_valid, out_halt); end
  endtask

  task automatic test_halt();
    drive(1'b1, 16'h0005, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0006, 1'b1, 1'b0);
    tick();
    checks++; if (in_ready !== 1'b0 || occupancy !== 2'd2) begin failures++; $display("FAIL halt_accept got rdy=%b occ=%0d exp rdy=0 occ=2", in_ready, occupancy); end
    drive(1'b1, 16'h0007, 1'b0, 1'b1);
    tick();
    checks++; if (out_data !== 16'h0006 || out_halt !== 1'b1 || halted !== 1'b0) begin failures++; $display("FAIL halt_main got data=%h halt=%b halted=%b exp data=0006 halt=1 halted=0", out_data, out_halt, halted); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL halt_locked got=%b exp=0", in_ready); end
    tick();
    checks++; if (halted !== 1'b1 || occupancy !== 2'd0 || in_ready !== 1'b0) begin failures++; $display("FAIL halt_fired got halted=%b occ=%0d rdy=%b exp halted=1 occ=0 rdy=0", halted, occupancy, in_ready); end
    flush = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    flush = 1'b0;
    checks++; if (halted !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL halt_sticky got halted=%b rdy=%b exp halted=1 rdy=0", halted, in_ready); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 16'h0011, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0022, 1'b0, 1'b0);
    tick();
    checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL rmid_setup got=%0d exp=2", occupancy); end
    nRST = 1'b0; flush = 1'b1;
    drive(1'b1, 16'h0033, 1'b1, 1'b1);
    tick();
    nRST = 1'b1; flush = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b0 || out_data !== RV || out_halt !== 1'b0) begin failures++; $display("FAIL rmid_out got v=%b data=%h halt=%b exp v=0 data=%h halt=0", out_valid, out_data, out_halt, RV); end
    checks++; if (occupancy !== 2'd0 || halted !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rmid_state got occ=%0d halted=%b rdy=%b exp occ=0 halted=0 rdy=1", occupancy, halted, in_ready); end
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL rmid_after got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid); end
  endtask

  initial begin
    nRST = 1'b0; flush = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_two();
    test_flush_before_halt();
    test_halt();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached without finishing");
    $fatal(1, "timeout");
  end
endmodule
